// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, functs
// and ALU control values, reused by the ALU and datapath.
package mc_control_fsm_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned ALU_CTL_W = 3;
    localparam int unsigned ALU_OP_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU control generation: fixed add/sub for address and branch math,
// funct-driven for R-type; unknown functs fall back to add and are flagged.
module alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  alu_op,
    input  logic [OP_W-1:0]      funct,
    output logic [ALU_CTL_W-1:0] ALU_control,
    output logic                 funct_illegal
);

    always_comb begin
        ALU_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_SUB: ALU_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  ALU_control = ALU_ADD;
                    FN_SUB:  ALU_control = ALU_SUB;
                    FN_AND:  ALU_control = ALU_AND;
                    FN_OR:   ALU_control = ALU_OR;
                    FN_SLT:  ALU_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: ALU_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main controller. Outputs decode from the current state;
// handshake-dependent enables follow mem_ready/zero in the same cycle.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic [ALU_CTL_W-1:0] ALU_control,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic                 illegal_op
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic                  w_funct_illegal;
    logic                  w_ir_write;
    logic                  w_mem_write;
    logic                  w_reg_write;
    logic                  w_pc_en;
    logic                  w_illegal_op;

    alu_decoder u_alu_decoder (
        .alu_op        (w_alu_op),
        .funct         (funct),
        .ALU_control   (ALU_control),
        .funct_illegal (w_funct_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALU_OP_ADD;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        iord         = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        w_reg_write  = 1'b0;
        pc_src       = 2'b00;
        w_pc_en      = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_en      = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWRITE: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next_state = S_FETCH;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                mem_to_reg   = 1'b1;
                w_next_state = S_FETCH;
            end
            // Unknown funct aborts the instruction before any register write.
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALU_OP_FUNCT;
                if (w_funct_illegal) begin
                    w_illegal_op = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_ALUWB;
                end
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                reg_dst      = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a    = 1'b1;
                w_alu_op     = ALU_OP_SUB;
                pc_src       = 2'b01;
                w_pc_en      = zero;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                w_pc_en      = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Reset must kill every enable at once, even while FETCH sees mem_ready high.
    assign ir_write   = w_ir_write   & reset_n;
    assign mem_write  = w_mem_write  & reset_n;
    assign reg_write  = w_reg_write  & reset_n;
    assign pc_en      = w_pc_en      & reset_n;
    assign illegal_op = w_illegal_op & reset_n;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: table of instructions with expected
// per-cycle output words, scoreboard queue, and hand-written wait/reset sequences.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALU_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;

    mc_control_fsm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ALU_control (ALU_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .iord        (iord),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          n;
        logic [15:0] exp [5];
    } vec_t;

    vec_t vecs [14];

    // {a, b[1:0], iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, pc_src[1:0], pc_en, illegal_op, alu[2:0]}
    function automatic logic [15:0] ow(input logic a, input logic [1:0] b, input logic io,
                                       input logic irw, input logic mw, input logic rd,
                                       input logic m2r, input logic rw, input logic [1:0] pcs,
                                       input logic pce, input logic ill, input logic [2:0] alu);
        return {a, b, io, irw, mw, rd, m2r, rw, pcs, pce, ill, alu};
    endfunction

    function automatic logic [15:0] act_word();
        return {alu_src_a, alu_src_b, iord, ir_write, mem_write, reg_dst, mem_to_reg,
                reg_write, pc_src, pc_en, illegal_op, ALU_control};
    endfunction

    logic [15:0] E_F_RDY, E_F_WAIT, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWR, E_MEMWB;
    logic [15:0] E_EX_ADD, E_EX_SUB, E_EX_AND, E_EX_OR, E_EX_SLT, E_EX_ILL, E_ALUWB;
    logic [15:0] E_BEQ1, E_BEQ0, E_ADDIEX, E_ADDIWB, E_JUMP;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Compare one cycle's outputs at the falling edge, then advance past the next rising edge.
    task automatic cycle_check();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            check(name_q.pop_front(), act_word(), exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int i, input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        vecs[i].name = nm;
        vecs[i].op   = op;
        vecs[i].fn   = fn;
        vecs[i].z    = z;
        vecs[i].n    = n;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = e2;
        vecs[i].exp[3] = e3;
        vecs[i].exp[4] = e4;
    endtask

    initial begin
        E_F_RDY   = ow(0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 3'b010);
        E_F_WAIT  = ow(0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_DEC     = ow(0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_DEC_ILL = ow(0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'b010);
        E_MEMADR  = ow(1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_MEMRD   = ow(0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_MEMWR   = ow(0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_MEMWB   = ow(0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 3'b010);
        E_EX_ADD  = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_EX_SUB  = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b110);
        E_EX_AND  = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000);
        E_EX_OR   = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b001);
        E_EX_SLT  = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b111);
        E_EX_ILL  = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'b010);
        E_ALUWB   = ow(0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 3'b010);
        E_BEQ1    = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 3'b110);
        E_BEQ0    = ow(1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 3'b110);
        E_ADDIEX  = ow(1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b010);
        E_ADDIWB  = ow(0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 3'b010);
        E_JUMP    = ow(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 3'b010);

        add_vec(0,  "lw",      6'b100011, 6'b000000, 0, 5, E_F_RDY, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB);
        add_vec(1,  "sw",      6'b101011, 6'b000000, 0, 4, E_F_RDY, E_DEC, E_MEMADR, E_MEMWR, 16'h0);
        add_vec(2,  "r_add",   6'b000000, 6'b100000, 0, 4, E_F_RDY, E_DEC, E_EX_ADD, E_ALUWB, 16'h0);
        add_vec(3,  "r_sub",   6'b000000, 6'b100010, 0, 4, E_F_RDY, E_DEC, E_EX_SUB, E_ALUWB, 16'h0);
        add_vec(4,  "r_and",   6'b000000, 6'b100100, 0, 4, E_F_RDY, E_DEC, E_EX_AND, E_ALUWB, 16'h0);
        add_vec(5,  "r_or",    6'b000000, 6'b100101, 0, 4, E_F_RDY, E_DEC, E_EX_OR,  E_ALUWB, 16'h0);
        add_vec(6,  "r_slt",   6'b000000, 6'b101010, 0, 4, E_F_RDY, E_DEC, E_EX_SLT, E_ALUWB, 16'h0);
        add_vec(7,  "r_badfn", 6'b000000, 6'b111111, 0, 3, E_F_RDY, E_DEC, E_EX_ILL, 16'h0, 16'h0);
        add_vec(8,  "addi",    6'b001000, 6'b000000, 0, 4, E_F_RDY, E_DEC, E_ADDIEX, E_ADDIWB, 16'h0);
        add_vec(9,  "beq_z1",  6'b000100, 6'b000000, 1, 3, E_F_RDY, E_DEC, E_BEQ1, 16'h0, 16'h0);
        add_vec(10, "beq_z0",  6'b000100, 6'b000000, 0, 3, E_F_RDY, E_DEC, E_BEQ0, 16'h0, 16'h0);
        add_vec(11, "j",       6'b000010, 6'b000000, 0, 3, E_F_RDY, E_DEC, E_JUMP, 16'h0, 16'h0);
        add_vec(12, "ill_3f",  6'b111111, 6'b000000, 0, 2, E_F_RDY, E_DEC_ILL, 16'h0, 16'h0, 16'h0);
        add_vec(13, "ill_01",  6'b000001, 6'b100000, 0, 2, E_F_RDY, E_DEC_ILL, 16'h0, 16'h0, 16'h0);

        // Reset held with mem_ready high: FETCH enables must stay low.
        reset_n   = 1'b0;
        opcode    = 6'b0;
        funct     = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("reset_state", act_word(), E_F_WAIT);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", act_word(), E_F_WAIT);
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;

        // FETCH waits on mem_ready.
        push("fetch_wait0", E_F_WAIT);
        cycle_check();
        push("fetch_wait1", E_F_WAIT);
        cycle_check();

        // Instruction table with mem_ready tied high; latency is implied by the next FETCH.
        foreach (vecs[i]) begin
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            zero      = vecs[i].z;
            mem_ready = 1'b1;
            for (int k = 0; k < vecs[i].n; k++)
                push($sformatf("%s_c%0d", vecs[i].name, k), vecs[i].exp[k]);
            for (int k = 0; k < vecs[i].n; k++)
                cycle_check();
        end

        // sw with three stalled memory cycles.
        opcode = 6'b101011;
        funct  = 6'b0;
        zero   = 1'b1;
        push("sww_fetch", E_F_RDY);  cycle_check();
        push("sww_dec",   E_DEC);    cycle_check();
        push("sww_adr",   E_MEMADR); cycle_check();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("sww_wait%0d", k), E_MEMWR);
            cycle_check();
        end
        mem_ready = 1'b1;
        push("sww_done", E_MEMWR);   cycle_check();
        mem_ready = 1'b0;
        push("sww_back_fetch", E_F_WAIT); cycle_check();

        // Asynchronous reset in the middle of a MEMREAD wait.
        opcode    = 6'b100011;
        zero      = 1'b0;
        mem_ready = 1'b1;
        push("rst_fetch", E_F_RDY);  cycle_check();
        push("rst_dec",   E_DEC);    cycle_check();
        push("rst_adr",   E_MEMADR); cycle_check();
        mem_ready = 1'b0;
        push("rst_memrd_wait", E_MEMRD); cycle_check();
        #2;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_async_fetch", act_word(), E_F_WAIT);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release_fetch", act_word(), E_F_RDY);
        @(posedge clk);
        #1;
        push("post_rst_dec",   E_DEC);    cycle_check();
        push("post_rst_adr",   E_MEMADR); cycle_check();
        push("post_rst_memrd", E_MEMRD);  cycle_check();
        push("post_rst_memwb", E_MEMWB);  cycle_check();
        mem_ready = 1'b0;
        push("post_rst_fetch", E_F_WAIT); cycle_check();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 The block SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: opcode  in  6  instr[31:26] from the instruction register.
REQ-004 The block SHALL have ports: funct  in  6  instr[5:0].
REQ-005 The block SHALL have ports: zero  in  1  ALU zero flag (valid on sub).
REQ-006 The block SHALL have ports: mem_ready  in  1  memory access-complete handshake.
REQ-007 The block SHALL have ports: ALU_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-008 The block SHALL have ports: alu_src_a out 1; alu_src_b out 2; iord out 1; ir_write out 1; mem_write out 1; reg_dst out 1; mem_to_reg out 1; reg_write out 1; pc_src out 2; pc_en out 1; illegal_op out 1.

Function
REQ-009 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP.
REQ-010 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01, ALU_control=010, pc_src=00; hold until mem_ready=1, then pulse ir_write and pc_en for that one cycle and go to DECODE.
REQ-011 DECODE SHALL compute the branch target (alu_src_a=0, alu_src_b=11, add) and branch on opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BEQ, 001000->ADDIEX, 000010->JUMP.
REQ-012 Any other opcode in DECODE SHALL pulse illegal_op for one cycle and return to FETCH with no register/memory write.
REQ-013 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, add; go to MEMREAD if lw else MEMWRITE.
REQ-014 MEMREAD (iord=1) and MEMWRITE (iord=1, mem_write=1) SHALL hold while mem_ready=0; MEMREAD->MEMWB, MEMWRITE->FETCH on mem_ready=1.
REQ-015 MEMWB SHALL assert reg_write=1, mem_to_reg=1, reg_dst=0 for one cycle, then FETCH.
REQ-016 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, ALU_control from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; then ALUWB.
REQ-017 Unknown funct in EXECUTE SHALL drive 010, pulse illegal_op, and go to FETCH, skipping ALUWB.
REQ-018 ALUWB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
REQ-019 BEQ SHALL drive alu_src_a=1, alu_src_b=00, ALU_control=110, pc_src=01, pc_en=zero (same-cycle, combinational), then FETCH.
REQ-020 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, add, then ADDIWB; ADDIWB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
REQ-021 JUMP SHALL drive pc_src=10, pc_en=1, then FETCH.
REQ-022 All outputs not listed for a state SHALL be 0 (ALU_control 010); no X on any output.
REQ-023 pc_en SHALL never assert outside FETCH(mem_ready), BEQ(zero), JUMP.
REQ-024 Per-instruction latency with mem_ready tied 1 SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force state FETCH and all write enables (ir_write, mem_write, reg_write, pc_en) and illegal_op to 0, including mid-instruction or mid-wait.
REQ-026 After deassertion, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-027 A shared package SHALL hold the state enum, opcode/funct constants and ALU_control encodings, for reuse by the ALU and datapath.
REQ-028 ALU_control generation SHALL be a sub-module alu_decoder (inputs alu_op[1:0], funct; outputs ALU_control, funct_illegal).

Verification
REQ-029 lw, opcode 100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 with mem_to_reg=1 only in cycle 5.
REQ-030 R-type funct 101010 -> ALU_control=111 in EXECUTE; reg_dst=1, reg_write=1 next cycle.
REQ-031 beq with zero=1 -> pc_en=1, pc_src=01 in BEQ; with zero=0 -> pc_en=0 throughout BEQ.
REQ-032 sw with mem_ready low 3 cycles in MEMWRITE -> mem_write held 4 cycles, then FETCH.
REQ-033 opcode 111111 -> illegal_op pulse one cycle in DECODE, no reg_write/mem_write, back to FETCH.
REQ-034 reset_n low during MEMREAD wait -> FETCH immediately, all enables 0 without a clock edge.
